// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU request arbiter.
package alu_arb_pkg;
    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one
// that did not win last time. Purely combinational.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic [0:0] last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = last[0] ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between the execute path (req 0) and the
// branch/address-compare path (req 1), returning results over valid/ready.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int XLEN    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_rs1,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_rs2,
    input  logic [NUM_REQ-1:0][2:0]       req_funct3,
    input  logic [NUM_REQ-1:0]            req_funct7,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [XLEN-1:0]               rsp_rd,
    output logic                          rsp_z,
    output logic [XLEN-1:0]               alu_rs1,
    output logic [XLEN-1:0]               alu_rs2,
    output logic [2:0]                    alu_funct3,
    output logic                          alu_funct7,
    input  logic [XLEN-1:0]               alu_rd,
    input  logic                          alu_z
);
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_grant;
    logic               r_last;
    logic [XLEN-1:0]    r_alu_rs1;
    logic [XLEN-1:0]    r_alu_rs2;
    logic [2:0]         r_alu_funct3;
    logic               r_alu_funct7;
    logic [XLEN-1:0]    r_rsp_rd;
    logic               r_rsp_z;

    logic [1:0]         w_gnt;
    logic               w_idx;
    logic               w_acc;

    rr_arbiter2 u_rr (
        .req  (req_valid),
        .last (r_last),
        .gnt  (w_gnt)
    );

    // Ready is gated by rst_n so it reads zero while reset is held.
    assign req_ready = (r_state == IDLE && rst_n) ? w_gnt : '0;
    assign w_idx     = w_gnt[1];
    assign w_acc     = |(req_valid & req_ready);
    assign rsp_valid = (r_state == RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;

    assign alu_rs1    = r_alu_rs1;
    assign alu_rs2    = r_alu_rs2;
    assign alu_funct3 = r_alu_funct3;
    assign alu_funct7 = r_alu_funct7;
    assign rsp_rd     = r_rsp_rd;
    assign rsp_z      = r_rsp_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_grant      <= 1'b0;
            r_last       <= 1'b1;
            r_alu_rs1    <= '0;
            r_alu_rs2    <= '0;
            r_alu_funct3 <= '0;
            r_alu_funct7 <= 1'b0;
            r_rsp_rd     <= '0;
            r_rsp_z      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_acc) begin
                    r_alu_rs1    <= req_rs1[w_idx];
                    r_alu_rs2    <= req_rs2[w_idx];
                    r_alu_funct3 <= req_funct3[w_idx];
                    r_alu_funct7 <= req_funct7[w_idx];
                    r_grant      <= w_idx;
                    r_last       <= w_idx;
                    r_cnt        <= CNT_W'(ALU_LAT);
                    r_state      <= BUSY;
                end
                // Counts ALU_LAT down to 0, so BUSY spans ALU_LAT+1 cycles.
                BUSY: if (r_cnt == '0) begin
                    r_rsp_rd <= alu_rd;
                    r_rsp_z  <= alu_z;
                    r_state  <= RESP;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
                RESP: if (rsp_ready[r_grant])
                    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small clocked ALU model attached.
module tb_alu_arbiter;
    localparam int ALU_LAT = 1;
    localparam int XLEN    = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            req_valid = '0;
    logic [1:0]            req_ready;
    logic [1:0][XLEN-1:0]  req_rs1 = '0;
    logic [1:0][XLEN-1:0]  req_rs2 = '0;
    logic [1:0][2:0]       req_funct3 = '0;
    logic [1:0]            req_funct7 = '0;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready = '0;
    logic [XLEN-1:0]       rsp_rd;
    logic                  rsp_z;
    logic [XLEN-1:0]       alu_rs1, alu_rs2, alu_rd;
    logic [2:0]            alu_funct3;
    logic                  alu_funct7, alu_z;

    int n_chk = 0;
    int n_err = 0;
    int cyc;

    alu_arbiter #(.ALU_LAT(ALU_LAT), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_funct3(req_funct3), .req_funct7(req_funct7),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rd(rsp_rd), .rsp_z(rsp_z),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_rd(alu_rd), .alu_z(alu_z)
    );

    always #5 clk = ~clk;

    // Reference ALU: one result per stage, ALU_LAT registered stages.
    function automatic logic [XLEN-1:0] alu_f(logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                                              logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return f7 ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b100:  return a ^ b;
            3'b101:  return f7 ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            3'b111:  return a & b;
            default: return '0;
        endcase
    endfunction

    logic [XLEN:0] pipe [ALU_LAT];
    initial for (int i = 0; i < ALU_LAT; i++) pipe[i] = '0;
    always @(posedge clk) begin
        pipe[0] <= {alu_f(alu_rs1, alu_rs2, alu_funct3, alu_funct7) == '0,
                     alu_f(alu_rs1, alu_rs2, alu_funct3, alu_funct7)};
        for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_rd = pipe[ALU_LAT-1][XLEN-1:0];
    assign alu_z  = pipe[ALU_LAT-1][XLEN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [2:0] f3, input logic f7);
        req_valid[r]  = v;
        req_rs1[r]    = a;
        req_rs2[r]    = b;
        req_funct3[r] = f3;
        req_funct7[r] = f7;
    endtask

    // Counts ticks until rsp_valid[r]; a timeout is a failed check.
    task automatic wait_rsp(input int r, output int n);
        n = 0;
        while (!rsp_valid[r] && n < 20) begin
            tick();
            n++;
        end
        if (!rsp_valid[r]) check("rsp_timeout", 32'(rsp_valid), 32'(2'b1 << r));
    endtask

    task automatic wait_ready(input string tag, input logic [1:0] exp);
        int n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(req_ready), 32'(exp));
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state, with both requesters asserting valid
        rst_n = 1'b0;
        req_valid = 2'b11;
        #12;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rd", rsp_rd, 0);
        check("rst_alu_rs1", alu_rs1, 0);
        check("rst_alu_f3", 32'(alu_funct3), 0);
        do_reset();

        // Single request: ADD 20+30, rsp_valid in cycle 3
        set_req(0, 1'b1, 20, 30, 3'b000, 1'b0);
        rsp_ready = 2'b11;
        #1;
        check("add_ready", 32'(req_ready), 32'(2'b01));
        tick();
        req_valid = '0;
        check("add_alu_rs1", alu_rs1, 20);
        check("add_alu_rs2", alu_rs2, 30);
        check("add_busy_ready", 32'(req_ready), 0);
        wait_rsp(0, cyc);
        check("add_latency", 32'(cyc), 32'(ALU_LAT + 1));
        check("add_rd", rsp_rd, 50);
        check("add_z", 32'(rsp_z), 0);
        check("add_rsp1", 32'(rsp_valid[1]), 0);
        tick();
        check("add_done", 32'(rsp_valid), 0);

        // Tie after reset: req0 SUB 8-3 first, then req1 AND 20&30
        do_reset();
        set_req(0, 1'b1, 8, 3, 3'b000, 1'b1);
        set_req(1, 1'b1, 20, 30, 3'b111, 1'b0);
        rsp_ready = 2'b11;
        #1;
        check("tie_ready", 32'(req_ready), 32'(2'b01));
        tick();
        req_valid[0] = 1'b0;
        check("tie_busy_ready1", 32'(req_ready), 0);
        wait_rsp(0, cyc);
        check("tie_rd0", rsp_rd, 5);
        check("tie_resp_ready1", 32'(req_ready), 0);
        tick();
        check("tie_ready1", 32'(req_ready), 32'(2'b10));
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(1, cyc);
        check("tie_rd1", rsp_rd, 20);
        check("tie_rsp0_low", 32'(rsp_valid[0]), 0);
        tick();

        // Fairness: both valid continuously, grants alternate 0,1,0,1
        do_reset();
        set_req(0, 1'b1, 1, 2, 3'b000, 1'b0);
        set_req(1, 1'b1, 12, 10, 3'b100, 1'b0);
        rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_ready($sformatf("fair_grant%0d", k), (k % 2) ? 2'b10 : 2'b01);
            tick();
            wait_rsp(k % 2, cyc);
            check($sformatf("fair_rd%0d", k), rsp_rd, (k % 2) ? 6 : 3);
            tick();
        end
        req_valid = '0;

        // Backpressure: req1 SLL 8<<3 held 5 cycles, req0 pending
        set_req(1, 1'b1, 8, 3, 3'b001, 1'b0);
        rsp_ready = 2'b01;
        #1;
        check("bp_ready1", 32'(req_ready), 32'(2'b10));
        tick();
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, 7, 9, 3'b110, 1'b0);
        #1;
        check("bp_busy_ready0", 32'(req_ready), 0);
        wait_rsp(1, cyc);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(rsp_valid), 32'(2'b10));
            check($sformatf("bp_rd%0d", i), rsp_rd, 64);
            check($sformatf("bp_ready0_%0d", i), 32'(req_ready), 0);
            tick();
        end
        rsp_ready = 2'b11;
        #1;
        check("bp_release_ready0", 32'(req_ready), 0);
        tick();
        check("bp_after_ready0", 32'(req_ready), 32'(2'b01));
        check("bp_after_valid", 32'(rsp_valid), 0);
        tick();
        req_valid = '0;
        wait_rsp(0, cyc);
        check("bp_rd0", rsp_rd, 15);
        tick();

        // Zero flag: SUB 20-20
        set_req(0, 1'b1, 20, 20, 3'b000, 1'b1);
        #1;
        wait_ready("zero_ready", 2'b01);
        tick();
        req_valid = '0;
        wait_rsp(0, cyc);
        check("zero_rd", rsp_rd, 0);
        check("zero_z", 32'(rsp_z), 1);
        tick();

        // Reset during BUSY aborts the op
        set_req(0, 1'b1, 5, 6, 3'b000, 1'b0);
        #1;
        tick();
        req_valid = '0;
        check("mid_alu_rs1", alu_rs1, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu_rs1", alu_rs1, 0);
        check("mid_rst_rsp_rd", rsp_rd, 0);
        check("mid_rst_valid", 32'(rsp_valid), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mid_no_rsp%0d", i), 32'(rsp_valid), 0);
        end
        set_req(0, 1'b1, 1, 1, 3'b000, 1'b0);
        set_req(1, 1'b1, 1, 1, 3'b000, 1'b0);
        #1;
        check("mid_new_grant", 32'(req_ready), 32'(2'b01));
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single clocked `alu` between two requesters: req 0 is the integer execute path, req 1 is the branch/address-compare path.
- Arbitrates round-robin and latches the granted operands onto the ALU inputs.
- Waits out the ALU latency, captures `rd` and `z`, and returns them to the winner over a valid/ready response channel with backpressure.

Parameters:
- ALU_LAT, 1, clock edges from ALU operand-stable to `rd`/`z` valid; legal range 1..7.
- XLEN, 32, operand and result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  [1:0]  request valid per requester.
- req_ready  out  [1:0]  request accepted this cycle (one-hot or zero).
- req_rs1  in  [1:0][XLEN-1:0]  operand A per requester.
- req_rs2  in  [1:0][XLEN-1:0]  operand B per requester.
- req_funct3  in  [1:0][2:0]  ALU op per requester.
- req_funct7  in  [1:0]  ALU op modifier (SUB/SRA) per requester.
- rsp_valid  out  [1:0]  result valid, routed to the granted requester only.
- rsp_ready  in  [1:0]  requester consumes result.
- rsp_rd  out  XLEN  captured result, shared bus.
- rsp_z  out  1  captured zero flag.
- alu_rs1  out  XLEN  to ALU rs1.
- alu_rs2  out  XLEN  to ALU rs2.
- alu_funct3  out  3  to ALU funct3.
- alu_funct7  out  1  to ALU funct7.
- alu_rd  in  XLEN  from ALU rd.
- alu_z  in  1  from ALU z.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, grant=0, last_grant=1 (req 0 wins the first tie).
  - All outputs 0: req_ready, rsp_valid, rsp_rd, rsp_z, and all alu_* outputs.
- Reset mid-operation aborts the operation; no response is ever issued for it.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - Grant is computed combinationally. Only one valid → that one wins. Both valid → the requester != last_grant wins.
  - req_ready[g]=1 for the winner only, and only in IDLE.
  - On an edge with req_valid[g]&req_ready[g]:
    - latch the operands into the alu_* registers;
    - grant<=g, last_grant<=g, cnt<=ALU_LAT;
    - go to BUSY.
  - No valid → stay in IDLE; alu_* hold their last values (no toggling).
- BUSY:
  - alu_* stay stable and req_ready=0.
  - cnt decrements each cycle.
  - On the edge where cnt==0: rsp_rd<=alu_rd, rsp_z<=alu_z, go to RESP.
  - BUSY therefore lasts ALU_LAT+1 cycles.
- RESP:
  - rsp_valid[grant]=1; the other bit is 0.
  - rsp_rd and rsp_z are held stable.
  - On rsp_ready[grant]=1 go to IDLE. The next accept can happen in the following cycle.
  - rsp_ready of the non-granted requester is ignored.
- Latency, with accept on cycle 0 edge:
  - alu_* valid from cycle 1;
  - capture at the end of cycle 1+ALU_LAT;
  - rsp_valid high from cycle 2+ALU_LAT.
  - ALU_LAT=1 gives rsp_valid in cycle 3.
- Throughput: at most one op per ALU_LAT+3 cycles when rsp_ready is held high.
- Protocol rules:
  - Requesters hold valid and operands stable until ready. This is not checked.
  - A requester deasserting valid before ready simply loses arbitration.
  - No new grant is issued while RESP is blocked; both requesters stall.
- Width rules: operands and result are passed through unmodified; the arbiter performs no arithmetic.

Decomposition:
- Package alu_arb_pkg holds:
  - the state typedef enum {IDLE, BUSY, RESP};
  - NUM_REQ=2;
  - the counter width localparam (3 bits).
- Sub-module rr_arbiter2 takes req[1:0] and last[0:0] and returns a one-hot gnt[1:0]. It is purely combinational and is reusable by later shared resources (e.g. the multiplier).

Test Plan:
- Single request: req0 ADD, rs1=20, rs2=30, funct3=000, funct7=0, ALU_LAT=1, rsp_ready=1 → rsp_valid[0] in cycle 3, rsp_rd=50, rsp_z=0, rsp_valid[1]=0 throughout.
- Tie: both valid in the same cycle after reset, req0 SUB 8-3 (000/1) and req1 AND 20&30 (111/0) → req0 served first with rsp_rd=5; then req1 with rsp_rd=20; req_ready[1] rises only after the first RESP completes.
- Fairness: both valid continuously for 4 ops → grant sequence 0,1,0,1; no requester is granted twice in a row.
- Backpressure: req1 SLL 8<<3, rsp_ready[1]=0 for 5 cycles → rsp_valid[1] and rsp_rd=64 held stable all 5 cycles; a pending req0 sees req_ready[0]=0 until the cycle after rsp_ready[1]=1.
- Zero flag: req0 SUB 20-20 → rsp_rd=0, rsp_z=1.
- Reset mid-op: assert rst_n=0 during BUSY → all outputs 0 immediately; after release, no rsp_valid for the aborted op; a new req0 is granted first.
